// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer for the EX stage.
// Drives a shared external 32-bit adder once per cycle; results land in HI/LO.
module muldiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic        op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        abort,
  output logic        busy,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_ci,
  input  logic [31:0] add_s,
  input  logic        add_co
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

  state_t      state_r, state_s;
  logic        op_r;
  logic [31:0] d_r;
  logic [31:0] a_r;
  logic [31:0] q_r;
  logic        dz_r;
  logic [4:0]  cnt_r;
  logic        busy_r;
  logic        result_valid_r;

  logic        accept_s;
  logic [31:0] rem_sh_s;
  logic        ok_s;
  logic [31:0] a_nxt_s;
  logic [31:0] q_nxt_s;

  assign accept_s = (state_r == S_IDLE) & start_valid & ~abort;

  // Next-state decode; abort dominates both accept and result handshake.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_valid) state_s = S_RUN;
          else             state_s = S_IDLE;
        end
        S_RUN: begin
          if (cnt_r == CNT_LAST) state_s = S_DONE;
          else                   state_s = S_RUN;
        end
        S_DONE: begin
          if (result_ready) state_s = S_IDLE;
          else              state_s = S_DONE;
        end
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Adder drive and one shift-add / restoring-divide step per RUN cycle.
  always_comb begin
    add_a    = 32'd0;
    add_b    = 32'd0;
    add_ci   = 1'b0;
    rem_sh_s = {a_r[30:0], q_r[31]};
    ok_s     = 1'b0;
    a_nxt_s  = a_r;
    q_nxt_s  = q_r;
    if (state_r == S_RUN) begin
      if (op_r) begin
        // Trial subtract R' - D as R' + ~D + 1; a set msb means R' >= 2^32 > D.
        add_a  = rem_sh_s;
        add_b  = ~d_r;
        add_ci = 1'b1;
        ok_s   = add_co | a_r[31];
        if (ok_s) a_nxt_s = add_s;
        else      a_nxt_s = rem_sh_s;
        q_nxt_s = {q_r[30:0], ok_s};
      end else begin
        add_a = a_r;
        if (q_r[0]) add_b = d_r;
        else        add_b = 32'd0;
        add_ci  = 1'b0;
        a_nxt_s = {add_co, add_s[31:1]};
        q_nxt_s = {add_s[0], q_r[31:1]};
      end
    end else begin
      add_a  = 32'd0;
      add_b  = 32'd0;
      add_ci = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Registered status flags, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      busy_r         <= (state_s == S_RUN);
      result_valid_r <= (state_s == S_DONE);
    end
  end

  // Operand capture and iteration datapath; abort leaves HI/LO untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= 1'b0;
      d_r   <= 32'd0;
      a_r   <= 32'd0;
      q_r   <= 32'd0;
      dz_r  <= 1'b0;
      cnt_r <= 5'd0;
    end else if (abort) begin
      cnt_r <= cnt_r;
    end else if (accept_s) begin
      op_r  <= op;
      d_r   <= opb;
      a_r   <= 32'd0;
      q_r   <= opa;
      dz_r  <= op & (opb == 32'd0);
      cnt_r <= 5'd0;
    end else if (state_r == S_RUN) begin
      a_r   <= a_nxt_s;
      q_r   <= q_nxt_s;
      cnt_r <= cnt_r + 5'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign start_ready  = (state_r == S_IDLE);
  assign busy         = busy_r;
  assign result_valid = result_valid_r;
  assign hi           = a_r;
  assign lo           = q_r;
  assign dz           = dz_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: models the shared adder and compares
// against a plain-arithmetic MULTU/DIVU reference.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid, start_ready, op, abort, busy;
  logic        result_valid, result_ready, dz, add_ci, add_co;
  logic [31:0] opa, opb, hi, lo, add_a, add_b, add_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};

  muldiv_seq #(.ITER(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .opa(opa), .opb(opb), .abort(abort),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .hi(hi), .lo(lo), .dz(dz),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co)
  );

  task automatic ref_calc(input bit o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l, output logic d);
    logic [63:0] p;
    if (!o) begin
      p = {32'd0, a} * {32'd0, b};
      h = p[63:32]; l = p[31:0]; d = 1'b0;
    end else if (b == 32'd0) begin
      h = a; l = 32'hFFFF_FFFF; d = 1'b1;
    end else begin
      h = a % b; l = a / b; d = 1'b0;
    end
  endtask

  // Issue one request and wait for result_valid; leaves the block in DONE.
  task automatic run_op(input bit o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic d,
                        output int lat, output int bc);
    int guard = 0;
    while (!start_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    start_valid = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start_valid = 1'b0; opa = $urandom; opb = $urandom; op = ~o;
    lat = 0; bc = 0;
    while (!result_valid && lat < 100) begin
      if (busy) bc++;
      @(posedge clk); #1; lat++;
    end
    h = hi; l = lo; d = dz;
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({start_ready, busy, result_valid, dz, add_ci} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags: got=%b exp=10000", {start_ready, busy, result_valid, dz, add_ci}); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got=%h exp=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got=%h exp=0", lo); end
    total++; if ({add_a, add_b} !== 64'd0) begin bad++; $display("FAIL reset_adder: got=%h exp=0", {add_a, add_b}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct { bit o; logic [31:0] a, b, h, l; } vec_t;

  task automatic test_directed();
    vec_t dv[5];
    logic [31:0] h, l; logic d; int lat, bc;
    dv[0] = '{1'b0, 32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A};
    dv[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    dv[2] = '{1'b1, 32'd100,        32'd7,          32'd2,         32'd14};
    dv[3] = '{1'b1, 32'h8000_0000,  32'd3,          32'd2,         32'h2AAA_AAAA};
    dv[4] = '{1'b1, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE, 32'd1};
    for (int i = 0; i < 5; i++) begin
      run_op(dv[i].o, dv[i].a, dv[i].b, h, l, d, lat, bc);
      total++; if (h !== dv[i].h) begin bad++; $display("FAIL dir%0d_hi: got=%h exp=%h", i, h, dv[i].h); end
      total++; if (l !== dv[i].l) begin bad++; $display("FAIL dir%0d_lo: got=%h exp=%h", i, l, dv[i].l); end
      total++; if (d !== 1'b0) begin bad++; $display("FAIL dir%0d_dz: got=%b exp=0", i, d); end
      total++; if (lat !== 32) begin bad++; $display("FAIL dir%0d_latency: got=%0d exp=32", i, lat); end
      total++; if (bc !== 32) begin bad++; $display("FAIL dir%0d_busy_cycles: got=%0d exp=32", i, bc); end
      release_result();
      total++; if ({start_ready, result_valid, busy} !== 3'b100) begin
        bad++; $display("FAIL dir%0d_release: got=%b exp=100", i, {start_ready, result_valid, busy}); end
    end
  endtask

  task automatic test_div_zero_hold();
    logic [31:0] h, l; logic d; int lat, bc;
    run_op(1'b1, 32'h1234_5678, 32'd0, h, l, d, lat, bc);
    total++; if ({d, h, l} !== {1'b1, 32'h1234_5678, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL dz_result: got=%b/%h/%h exp=1/12345678/ffffffff", d, h, l); end
    total++; if (lat !== 32) begin bad++; $display("FAIL dz_latency: got=%0d exp=32", lat); end
    start_valid = 1'b1; op = 1'b0; opa = 32'd3; opb = 32'd5;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if ({result_valid, start_ready, busy, dz, hi, lo} !== {4'b1001, 32'h1234_5678, 32'hFFFF_FFFF}) begin
        bad++; $display("FAIL dz_hold%0d: got=%b%b%b%b/%h/%h exp=1001/12345678/ffffffff",
                        c, result_valid, start_ready, busy, dz, hi, lo); end
      total++; if ({add_a, add_b, add_ci} !== 65'd0) begin
        bad++; $display("FAIL dz_adder_idle%0d: got=%h exp=0", c, {add_a, add_b, add_ci}); end
    end
    start_valid = 1'b0;
    release_result();
  endtask

  task automatic test_random();
    logic [31:0] a, b, h, l, eh, el; logic d, ed; bit o; int lat, bc;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      ref_calc(o, a, b, eh, el, ed);
      run_op(o, a, b, h, l, d, lat, bc);
      total++; if ({h, l, d} !== {eh, el, ed}) begin
        bad++; $display("FAIL rand%0d op=%0d a=%h b=%h: got=%h/%h/%b exp=%h/%h/%b",
                        i, o, a, b, h, l, d, eh, el, ed); end
      total++; if (lat !== 32) begin bad++; $display("FAIL rand%0d_latency: got=%0d exp=32", i, lat); end
      release_result();
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    start_valid = 1'b1; op = 1'b0; opa = $urandom; opb = $urandom;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy: got=%b exp=1", busy); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++; if ({start_ready, busy, result_valid} !== 3'b100) begin
      bad++; $display("FAIL abort_idle: got=%b exp=100", {start_ready, busy, result_valid}); end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (result_valid || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_result: got=%0d exp=0", seen); end
  endtask

  task automatic test_abort_accept();
    start_valid = 1'b1; abort = 1'b1; op = 1'b1; opa = 32'd9; opb = 32'd2;
    @(posedge clk); #1;
    start_valid = 1'b0; abort = 1'b0;
    total++; if ({start_ready, busy} !== 2'b10) begin
      bad++; $display("FAIL abort_vs_accept: got=%b exp=10", {start_ready, busy}); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] h, l, eh, el; logic d, ed; int lat, bc;
    start_valid = 1'b1; op = 1'b1; opa = 32'hDEAD_BEEF; opb = 32'd13;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if ({start_ready, busy, result_valid, dz, add_ci, hi, lo, add_a, add_b} !== {5'b10000, 128'd0}) begin
      bad++; $display("FAIL rst_mid_run: got=%b%b%b%b%b/%h/%h/%h/%h exp=10000/0/0/0/0",
                      start_ready, busy, result_valid, dz, add_ci, hi, lo, add_a, add_b); end
    @(posedge clk); #1 rst_n = 1'b1;
    ref_calc(1'b0, 32'h0001_0001, 32'h0003_0007, eh, el, ed);
    run_op(1'b0, 32'h0001_0001, 32'h0003_0007, h, l, d, lat, bc);
    total++; if ({h, l, d} !== {eh, el, ed}) begin
      bad++; $display("FAIL rst_recover: got=%h/%h/%b exp=%h/%h/%b", h, l, d, eh, el, ed); end
    release_result();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start_valid = 1'b0; op = 1'b0; opa = 32'd0; opb = 32'd0;
    abort = 1'b0; result_ready = 1'b0;
    test_reset();
    test_directed();
    test_div_zero_hold();
    test_random();
    test_abort();
    test_abort_accept();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
